mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter for one shared 12-bit address port (instruction fetch = port 0, data access = port 1).
//  Sequences access windows of LAT cycles and drives the select of an internal _12bit_mux2_1 that steers addr0/addr1 onto port_addr.
//  Round-robin on ties, so neither requester starves.
//  Sits between the fetch/memory stages and the single-ported memory address bus.
// PARAMETERS
//  LAT  2  cycles the port is held per grant; legal range 1..15; cnt is 4 bits
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  req0       in   1   port 0 request (level); addr0 stable while req0=1
//  addr0      in   12  port 0 address
//  req1       in   1   port 1 request (level); addr1 stable while req1=1
//  addr1      in   12  port 1 address
//  gnt0       out  1   port 0 owns shared port this cycle
//  gnt1       out  1   port 1 owns shared port this cycle
//  done0      out  1   1-cycle pulse: last cycle of a port 0 grant
//  done1      out  1   1-cycle pulse: last cycle of a port 1 grant
//  mux_sel    out  1   select driven to _12bit_mux2_1 (0 = addr0, 1 = addr1)
//  port_addr  out  12  mux output = mux_sel ? addr1 : addr0 (combinational through mux)
//  port_en    out  1   shared port active (= gnt0 | gnt1)
//  busy       out  1   FSM in GRANT state
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE; gnt0=gnt1=done0=done1=port_en=busy=0; mux_sel=0; cnt=0; last_winner=1.
//  All outputs are registered except port_addr.
//  States: IDLE, GRANT. cnt counts the remaining grant cycles.
//  IDLE, evaluated each edge:
//   - no req: stay IDLE; mux_sel holds its value.
//   - exactly one req: grant it.
//   - both req: grant ~last_winner.
//  Grant i, next edge: state=GRANT, gnt_i=1, mux_sel=i, port_en=1, busy=1, cnt=LAT-1, last_winner=i.
//   - Latency from req to gnt is 1 cycle.
//  GRANT with cnt>0: cnt decrements; gnt/mux_sel held.
//  done_i=1 exactly in the grant cycle where cnt==0 (LAT=1: the only grant cycle).
//  End of grant (edge leaving the cnt==0 cycle), owner i:
//   - req of the other port =1: switch directly to grant other (no bubble); mux_sel flips same edge.
//   - otherwise: go IDLE; all gnt/port_en/busy/done clear.
//  req_i in its own done cycle is ignored, so a continuously asserting lone requester gets one IDLE bubble between grants.
//  gnt0 & gnt1 never both 1; done_i only while gnt_i=1.
//  No preemption: a request arriving mid-grant waits for end of grant.
//  Reset mid-grant: next cycle is IDLE with reset values; aborted access gets no done pulse.
//  Dropping req mid-grant does not shorten the grant.
// TESTING
//  1. rst, then req0=1, addr0=12'h0A5 alone (LAT=2) -> gnt0 in cycles 1-2, port_addr=12'h0A5, done0 in cycle 2, IDLE in cycle 3.
//  2. req0 and req1 raised same cycle after reset (addr1=12'hF3C) -> gnt0 2 cycles, then gnt1 immediately (no bubble), port_addr 0A5->F3C, done0 then done1.
//  3. req0 and req1 held high 20 cycles -> grants alternate 0,1,0,1..., each LAT cycles, port_en continuously 1.
//  4. req1 held high alone -> gnt1 2 cycles, 1 IDLE cycle, repeat; done1 every 3 cycles.
//  5. rst pulsed in first gnt1 cycle -> next cycle all outputs 0, no done1; then tie resolves to port 0 (last_winner=1).
//  6. LAT=1 build, req0 held, req1 pulsed once -> done0 coincides with each single-cycle gnt0; gnt1 in the cycle after the current gnt0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter granting one shared 12-bit address port in LAT-cycle windows.
// All outputs are registered except port_addr, which passes combinationally through the address mux.
module _12bit_mux2_1 (
    input  logic        sel,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] y
);
    assign y = sel ? b : a;
endmodule

module mem_port_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [11:0] addr0,
    input  logic        req1,
    input  logic [11:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        mux_sel,
    output logic [11:0] port_addr,
    output logic        port_en,
    output logic        busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       last_winner, last_n, sel_n, take, id, busy_n;
    always_comb begin
        take    = 1'b0;
        id      = 1'b0;
        state_n = state;
        cnt_n   = cnt;
        sel_n   = mux_sel;
        last_n  = last_winner;
        // At the end of a grant only the other port may take over; the owner's own request waits.
        if (state == IDLE) begin
            take = req0 | req1;
            id   = (req0 & req1) ? ~last_winner : req1;
        end else if (cnt == 4'd0) begin
            take = mux_sel ? req0 : req1;
            id   = ~mux_sel;
        end
        if (take) begin
            state_n = GRANT;
            cnt_n   = LAT_M1;
            sel_n   = id;
            last_n  = id;
        end else if (state == GRANT && cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
        end else begin
            state_n = IDLE;
        end
        busy_n = (state_n == GRANT);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_winner <= 1'b1;
            mux_sel     <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            port_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_winner <= last_n;
            mux_sel     <= sel_n;
            gnt0        <= busy_n & ~sel_n;
            gnt1        <= busy_n & sel_n;
            done0       <= busy_n & ~sel_n & (cnt_n == 4'd0);
            done1       <= busy_n & sel_n & (cnt_n == 4'd0);
            port_en     <= busy_n;
            busy        <= busy_n;
        end
    end
    _12bit_mux2_1 u_mux (
        .sel(mux_sel),
        .a  (addr0),
        .b  (addr1),
        .y  (port_addr)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives a LAT=2 and a LAT=1 arbiter with the same stimulus and compares both
// against a cycle-level ownership model (owner, remaining cycles, last winner).
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [11:0] addr0 = 12'h0, addr1 = 12'h0;
    logic [1:0]  gnt0, gnt1, done0, done1, mux_sel, port_en, busy;
    logic [11:0] port_addr [2];
    int checks = 0, errors = 0;
    int owner [2], rem [2], lw [2], sel [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]), .mux_sel(mux_sel[0]),
        .port_addr(port_addr[0]), .port_en(port_en[0]), .busy(busy[0])
    );
    mem_port_arbiter #(.LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]), .mux_sel(mux_sel[1]),
        .port_addr(port_addr[1]), .port_en(port_en[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grant(input int k, input int o);
        owner[k] = o;
        rem[k]   = (k == 0) ? 2 : 1;
        lw[k]    = o;
        sel[k]   = o;
    endtask

    // One clock edge of the arbitration rules; rem counts grant cycles left including the current one.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                owner[k] = -1; rem[k] = 0; lw[k] = 1; sel[k] = 0;
            end else if (owner[k] < 0) begin
                if (req0 || req1) grant(k, (req0 && req1) ? 1 - lw[k] : (req1 ? 1 : 0));
            end else if (rem[k] > 1) begin
                rem[k]--;
            end else if (owner[k] == 0 ? req1 : req0) begin
                grant(k, 1 - owner[k]);
            end else begin
                owner[k] = -1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt0[%0d]", k), 12'(gnt0[k]), 12'(owner[k] == 0));
            chk($sformatf("gnt1[%0d]", k), 12'(gnt1[k]), 12'(owner[k] == 1));
            chk($sformatf("done0[%0d]", k), 12'(done0[k]), 12'(owner[k] == 0 && rem[k] == 1));
            chk($sformatf("done1[%0d]", k), 12'(done1[k]), 12'(owner[k] == 1 && rem[k] == 1));
            chk($sformatf("mux_sel[%0d]", k), 12'(mux_sel[k]), 12'(sel[k]));
            chk($sformatf("port_en[%0d]", k), 12'(port_en[k]), 12'(owner[k] >= 0));
            chk($sformatf("busy[%0d]", k), 12'(busy[k]), 12'(owner[k] >= 0));
            chk($sformatf("port_addr[%0d]", k), port_addr[k], sel[k] != 0 ? addr1 : addr0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1 check_all();
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1; step(1); rst = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        // lone port 0 request
        req0 = 1'b1; addr0 = 12'h0A5;
        step(1);
        chk("t1_gnt0", 12'(gnt0[0]), 12'd1);
        chk("t1_addr", port_addr[0], 12'h0A5);
        req0 = 1'b0;
        step(1);
        chk("t1_done0", 12'(done0[0]), 12'd1);
        step(1);
        chk("t1_idle", 12'(busy[0]), 12'd0);
        // simultaneous requests after reset: port 0 first, then port 1 with no bubble
        pulse_rst();
        req0 = 1'b1; req1 = 1'b1; addr1 = 12'hF3C;
        step(1);
        chk("t2_gnt0", 12'(gnt0[0]), 12'd1);
        req0 = 1'b0;
        step(2);
        chk("t2_gnt1", 12'(gnt1[0]), 12'd1);
        chk("t2_addr", port_addr[0], 12'hF3C);
        req1 = 1'b0;
        step(3);
        // both held: alternating grants, port continuously busy
        pulse_rst();
        req0 = 1'b1; req1 = 1'b1;
        step(1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t3_port_en", 12'(port_en[0]), 12'd1);
        end
        req0 = 1'b0; req1 = 1'b0;
        step(3);
        // lone port 1 held: one idle bubble between grants
        req1 = 1'b1;
        step(9);
        req1 = 1'b0;
        step(3);
        // reset during the first port 1 grant cycle
        pulse_rst();
        req1 = 1'b1;
        step(1);
        chk("t5_gnt1", 12'(gnt1[0]), 12'd1);
        rst = 1'b1;
        step(1);
        chk("t5_busy", 12'(busy[0]), 12'd0);
        chk("t5_done1", 12'(done1[0]), 12'd0);
        rst = 1'b0; req0 = 1'b1;
        step(1);
        chk("t5_tie_gnt0", 12'(gnt0[0]), 12'd1);
        req0 = 1'b0; req1 = 1'b0;
        step(4);
        // port 0 held, port 1 pulsed once (exercises the LAT=1 instance)
        req0 = 1'b1;
        step(2);
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        step(6);
        req0 = 1'b0;
        step(3);
        // randomized traffic; addresses only change while their request is low
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            if (!req0) addr0 = 12'($urandom);
            if (!req1) addr1 = 12'($urandom);
            step(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
